// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command arbiter: SPI master register map,
// command-word encoding and the arbiter FSM state encoding.
package spi_cmd_pkg;

   // SPI master register addresses
   localparam logic [7:0] ADR_TX0    = 8'h00;
   localparam logic [7:0] ADR_CTRL   = 8'h10;
   localparam logic [7:0] ADR_DIVIDE = 8'h14;
   localparam logic [7:0] ADR_SS     = 8'h18;

   // CTRL bit that starts a transfer
   localparam logic [31:0] GO_MASK = 32'h0000_0100;

   // cmd_word[33:32] prefix marking a register write
   localparam logic [1:0] WR_FLAG = 2'b01;

   typedef enum logic [2:0] {
      ST_INIT_DIV,
      ST_INIT_CTRL,
      ST_IDLE,
      ST_WR_SS,
      ST_WR_TX,
      ST_WR_GO,
      ST_WAIT_INT
   } arb_state_e;

endpackage

// File: rtl/spi_reg_writer.sv
// Three-cycle register write engine for the SPI master command port.
// A start pulse latches adr/data; the following cycle is the setup cycle
// (cmd_stb low), then cmd_stb is high for two cycles. adr/cmd_word stay
// constant for the whole write and hold their value afterwards.
// done_o is high during the last strobe cycle so the sequencer can issue
// the next start in that same cycle and keep writes back to back.
module spi_reg_writer
   import spi_cmd_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [7:0]  adr_i,
   input  logic [31:0] data_i,
   output logic [7:0]  adr_o,
   output logic [33:0] cmd_word_o,
   output logic        cmd_stb_o,
   output logic        done_o
);

   logic [1:0]  cnt_q,  cnt_d;
   logic [7:0]  adr_q,  adr_d;
   logic [33:0] word_q, word_d;
   logic        stb_q,  stb_d;

   // phase counter: 0 idle, 1 setup, 2/3 strobe
   always_comb begin
      cnt_d  = cnt_q;
      adr_d  = adr_q;
      word_d = word_q;
      stb_d  = 1'b0;
      if (start_i) begin
         cnt_d  = 2'd1;
         adr_d  = adr_i;
         word_d = {WR_FLAG, data_i};
      end else begin
         case (cnt_q)
            2'd1: begin
               cnt_d = 2'd2;
               stb_d = 1'b1;
            end
            2'd2: begin
               cnt_d = 2'd3;
               stb_d = 1'b1;
            end
            default: cnt_d = 2'd0;
         endcase
      end
   end

   // output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= 2'd0;
         adr_q  <= 8'h00;
         word_q <= '0;
         stb_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         adr_q  <= adr_d;
         word_q <= word_d;
         stb_q  <= stb_d;
      end
   end

   assign adr_o      = adr_q;
   assign cmd_word_o = word_q;
   assign cmd_stb_o  = stb_q;
   assign done_o     = (cnt_q == 2'd3);

endmodule

// File: rtl/spi_dac_cmd_arbiter.sv
// Round-robin arbiter sharing the SPI master command port between NREQ
// 16-bit requesters. After reset DIVIDE and CTRL are programmed once; then
// each granted word is sent as [SS write if target changed], TX0 write,
// CTRL|GO write, followed by a wait for the master's interrupt.
//
// Handshake: requester i raises req[i] with req_dat word i stable and holds
// both until gnt[i] pulses for one cycle; the word is captured on the edge
// that raises gnt. Dropping req before the grant withdraws the request.
module spi_dac_cmd_arbiter
   import spi_cmd_pkg::*;
#(
   parameter int          NREQ     = 4,
   parameter logic [31:0] DIVIDER  = 32'h0,
   parameter logic [31:0] CTRL_CFG = 32'h3010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic [16*NREQ-1:0] req_dat,
   output logic [NREQ-1:0]  gnt,
   input  logic             int_o,
   output logic [7:0]       adr,
   output logic [33:0]      cmd_word,
   output logic             cmd_stb,
   output logic             busy,
   output logic             init_done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e      state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   last_ss_q, last_ss_d;
   logic            ss_valid_q, ss_valid_d;
   logic [15:0]     data_q, data_d;
   logic            busy_q, busy_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            init_done_q, init_done_d;
   logic            div_pend_q, div_pend_d;
   logic            wait_first_q, wait_first_d;

   logic            wr_start;
   logic [7:0]      wr_adr;
   logic [31:0]     wr_data;
   logic            wr_done;

   logic [15:0]     words [NREQ];
   logic            pick_found;
   logic [IW-1:0]   pick_idx;

   for (genvar g = 0; g < NREQ; g++) begin : g_words
      assign words[g] = req_dat[16*g +: 16];
   end

   // round-robin pick: first set req bit after ptr_q, wrapping
   always_comb begin
      int j;
      j          = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         j = (int'(ptr_q) + k) % NREQ;
         if (req[IW'(j)]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(j);
         end
      end
   end

   // sequencer: next state, write launches and grant bookkeeping
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      last_ss_d    = last_ss_q;
      ss_valid_d   = ss_valid_q;
      data_d       = data_q;
      busy_d       = busy_q;
      gnt_d        = '0;
      init_done_d  = init_done_q;
      div_pend_d   = div_pend_q;
      wait_first_d = wait_first_q;
      wr_start     = 1'b0;
      wr_adr       = ADR_TX0;
      wr_data      = '0;
      case (state_q)
         ST_INIT_DIV: begin
            if (div_pend_q) begin
               wr_start   = 1'b1;
               wr_adr     = ADR_DIVIDE;
               wr_data    = DIVIDER;
               div_pend_d = 1'b0;
            end else if (wr_done) begin
               wr_start = 1'b1;
               wr_adr   = ADR_CTRL;
               wr_data  = CTRL_CFG;
               state_d  = ST_INIT_CTRL;
            end
         end
         ST_INIT_CTRL: begin
            if (wr_done) begin
               init_done_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (pick_found) begin
               gnt_d  = NREQ'(1) << pick_idx;
               ptr_d  = pick_idx;
               data_d = words[pick_idx];
               busy_d = 1'b1;
               wr_start = 1'b1;
               if (!ss_valid_q || (pick_idx != last_ss_q)) begin
                  wr_adr     = ADR_SS;
                  wr_data    = 32'h1 << pick_idx;
                  last_ss_d  = pick_idx;
                  ss_valid_d = 1'b1;
                  state_d    = ST_WR_SS;
               end else begin
                  wr_adr  = ADR_TX0;
                  wr_data = {16'h0, words[pick_idx]};
                  state_d = ST_WR_TX;
               end
            end
         end
         ST_WR_SS: begin
            if (wr_done) begin
               wr_start = 1'b1;
               wr_adr   = ADR_TX0;
               wr_data  = {16'h0, data_q};
               state_d  = ST_WR_TX;
            end
         end
         ST_WR_TX: begin
            if (wr_done) begin
               wr_start = 1'b1;
               wr_adr   = ADR_CTRL;
               wr_data  = CTRL_CFG | GO_MASK;
               state_d  = ST_WR_GO;
            end
         end
         ST_WR_GO: begin
            if (wr_done) begin
               wait_first_d = 1'b1;
               state_d      = ST_WAIT_INT;
            end
         end
         ST_WAIT_INT: begin
            // the master clears its interrupt on the GO access, so the
            // first cycle here may still show the previous level
            if (wait_first_q) begin
               wait_first_d = 1'b0;
            end else if (int_o) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_INIT_DIV;
      endcase
   end

   // state and bookkeeping registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_INIT_DIV;
         ptr_q        <= IW'(NREQ - 1);
         last_ss_q    <= '0;
         ss_valid_q   <= 1'b0;
         data_q       <= '0;
         busy_q       <= 1'b0;
         gnt_q        <= '0;
         init_done_q  <= 1'b0;
         div_pend_q   <= 1'b1;
         wait_first_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         last_ss_q    <= last_ss_d;
         ss_valid_q   <= ss_valid_d;
         data_q       <= data_d;
         busy_q       <= busy_d;
         gnt_q        <= gnt_d;
         init_done_q  <= init_done_d;
         div_pend_q   <= div_pend_d;
         wait_first_q <= wait_first_d;
      end
   end

   spi_reg_writer u_writer (
      .clk        (clk),
      .rst        (rst),
      .start_i    (wr_start),
      .adr_i      (wr_adr),
      .data_i     (wr_data),
      .adr_o      (adr),
      .cmd_word_o (cmd_word),
      .cmd_stb_o  (cmd_stb),
      .done_o     (wr_done)
   );

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_spi_dac_cmd_arbiter.sv
// Bench for spi_dac_cmd_arbiter: register writes and grants are checked
// against expected queues filled when stimulus is driven; cycle-exact
// timing is checked inline for the init, grant and interrupt paths.
module tb_spi_dac_cmd_arbiter;

   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [16*NREQ-1:0] req_dat;
   logic [NREQ-1:0]   gnt;
   logic              int_o;
   logic [7:0]        adr;
   logic [33:0]       cmd_word;
   logic              cmd_stb;
   logic              busy;
   logic              init_done;

   int total = 0;
   int bad   = 0;

   logic [41:0]     exp_q[$];
   logic [NREQ-1:0] gnt_exp_q[$];

   logic [9:0] stb_pat;
   logic       auto_int = 1'b0;
   int         go_cnt = 0;
   int         go_served = 0;

   spi_dac_cmd_arbiter #(
      .NREQ     (NREQ),
      .DIVIDER  (32'h0),
      .CTRL_CFG (32'h3010)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_dat   (req_dat),
      .gnt       (gnt),
      .int_o     (int_o),
      .adr       (adr),
      .cmd_word  (cmd_word),
      .cmd_stb   (cmd_stb),
      .busy      (busy),
      .init_done (init_done)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
      exp_q.push_back({a, 2'b01, d});
   endtask

   task automatic push_xfer(input int idx, input logic [15:0] d, input bit with_ss);
      if (with_ss) push_wr(8'h18, 32'h1 << idx);
      push_wr(8'h00, {16'h0, d});
      push_wr(8'h10, 32'h3110);
      gnt_exp_q.push_back(NREQ'(1) << idx);
   endtask

   // raise req[idx] and hold it until granted; returns on the grant cycle
   task automatic do_req(input int idx, input logic [15:0] d);
      int n;
      n = 0;
      req_dat[16*idx +: 16] = d;
      req[idx] = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!gnt[idx] && n < 500);
      if (!gnt[idx]) check_eq("gnt_timeout", 64'd0, 64'd1);
      req[idx] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || exp_q.size() != 0 || gnt_exp_q.size() != 0) && n < 600);
      check_eq("idle_timeout", 64'(busy), 64'd0);
   endtask

   // scoreboard: each write checked on strobe rise, grants on every pulse
   logic [41:0] prev_bus = '0;
   logic [41:0] bus_now;
   logic        stb_prev = 1'b0;
   int          stb_len = 0;
   always @(negedge clk) begin
      bus_now = {adr, cmd_word};
      if (rst) begin
         stb_prev = 1'b0;
         stb_len  = 0;
      end else begin
         if (cmd_stb && !stb_prev) begin
            check_eq("wr_setup_hold", 64'(prev_bus), 64'(bus_now));
            if (exp_q.size() == 0) begin
               check_eq("wr_extra", 64'(bus_now), 64'd0);
            end else begin
               check_eq("wr_data", 64'(bus_now), 64'(exp_q.pop_front()));
            end
            if (adr == 8'h10 && cmd_word[8]) go_cnt++;
         end
         if (cmd_stb && stb_prev) check_eq("wr_stb_hold", 64'(prev_bus), 64'(bus_now));
         if (cmd_stb) begin
            stb_len++;
         end else if (stb_prev) begin
            check_eq("stb_len", 64'(stb_len), 64'd2);
            stb_len = 0;
         end
         stb_prev = cmd_stb;
         if (gnt != '0) begin
            if (gnt_exp_q.size() == 0) check_eq("gnt_extra", 64'(gnt), 64'd0);
            else check_eq("gnt", 64'(gnt), 64'(gnt_exp_q.pop_front()));
         end
      end
      prev_bus = bus_now;
   end

   // interrupt model: answer each GO a few cycles later when enabled
   initial begin
      forever begin
         @(negedge clk);
         if (go_cnt != go_served) begin
            go_served = go_cnt;
            if (auto_int) begin
               repeat (6) @(negedge clk);
               int_o = 1'b1;
               for (int n = 0; n < 50 && busy; n++) @(negedge clk);
               int_o = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      stb_pat = 10'b0110110110;
      req     = '0;
      req_dat = '0;
      int_o   = 1'b0;
      rst     = 1'b0;
      #1 rst  = 1'b1;
      repeat (3) @(negedge clk);

      // ---- reset values and init sequence ----
      check_eq("rst_adr", 64'(adr), 64'd0);
      check_eq("rst_word", 64'(cmd_word), 64'd0);
      check_eq("rst_stb", 64'(cmd_stb), 64'd0);
      check_eq("rst_gnt", 64'(gnt), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_init_done", 64'(init_done), 64'd0);
      push_wr(8'h14, 32'h0);
      push_wr(8'h10, 32'h3010);
      rst = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         @(negedge clk);
         check_eq("init_stb", 64'(cmd_stb), 64'(stb_pat[n-1]));
         check_eq("init_done", 64'(init_done), 64'(n == 7));
         check_eq("init_busy", 64'(busy), 64'd0);
      end
      repeat (3) @(negedge clk);
      check_eq("init_q_empty", 64'(exp_q.size()), 64'd0);

      // ---- all requesters held: round robin 0,1,2,3,0 ----
      auto_int = 1'b1;
      req_dat  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      for (int i = 0; i < 5; i++) push_xfer(i % NREQ, 16'h1000 + 16'(i % NREQ), 1'b1);
      req = '1;
      begin
         int seen;
         int n;
         seen = 0;
         n = 0;
         while (seen < 5 && n < 2000) begin
            @(negedge clk);
            n++;
            if (gnt != '0) seen++;
            if (seen == 5) req = '0;
         end
         req = '0;
         check_eq("rr_grants", 64'(seen), 64'd5);
      end
      wait_idle();

      // ---- single request, exact timing, busy until interrupt ----
      auto_int = 1'b0;
      push_xfer(2, 16'hABCD, 1'b1);
      do_req(2, 16'hABCD);
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) @(negedge clk);
         if (k <= 9) begin
            check_eq("t2_stb", 64'(cmd_stb), 64'(stb_pat[k]));
            check_eq("t2_busy", 64'(busy), 64'd1);
         end
         if (k == 0) check_eq("t2_ss_adr", 64'(adr), 64'h18);
         if (k == 9) check_eq("t2_go_adr", 64'(adr), 64'h10);
         if (k == 15) begin
            check_eq("t2_busy_wait", 64'(busy), 64'd1);
            int_o = 1'b1;
         end
         if (k == 16) begin
            check_eq("t2_busy_clr", 64'(busy), 64'd0);
            int_o = 1'b0;
         end
      end
      wait_idle();

      // ---- back-to-back from requester 1, withdrawn req[0] ----
      auto_int = 1'b1;
      push_xfer(1, 16'h1111, 1'b1);
      push_xfer(1, 16'h2222, 1'b0);
      do_req(1, 16'h1111);
      req[0] = 1'b1;
      repeat (2) @(negedge clk);
      req[0] = 1'b0;
      do_req(1, 16'h2222);
      check_eq("t4_tx_adr", 64'(adr), 64'h00);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 3) check_eq("t4_go_setup", 64'(cmd_stb), 64'd0);
         if (k == 4 || k == 5) begin
            check_eq("t4_go_stb", 64'(cmd_stb), 64'd1);
            check_eq("t4_go_adr", 64'(adr), 64'h10);
         end
         if (k == 6) check_eq("t4_go_end", 64'(cmd_stb), 64'd0);
      end
      wait_idle();

      // ---- int_o high outside the valid window is ignored ----
      auto_int = 1'b0;
      push_xfer(3, 16'h5555, 1'b1);
      do_req(3, 16'h5555);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 3) int_o = 1'b1;
         if (k == 6) int_o = 1'b0;
         if (k == 9) int_o = 1'b1;
         if (k == 10) int_o = 1'b0;
         if (k == 12) check_eq("t5_busy_12", 64'(busy), 64'd1);
         if (k == 13) begin
            check_eq("t5_busy_13", 64'(busy), 64'd1);
            int_o = 1'b1;
         end
         if (k == 14) begin
            check_eq("t5_busy_clr", 64'(busy), 64'd0);
            int_o = 1'b0;
         end
      end
      wait_idle();

      // ---- reset during TX strobe, SS forced afterwards ----
      push_wr(8'h00, {16'h0, 16'h3333});
      gnt_exp_q.push_back(4'b1000);
      do_req(3, 16'h3333);
      @(negedge clk);
      check_eq("t6_tx_stb", 64'(cmd_stb), 64'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("t6_rst_stb", 64'(cmd_stb), 64'd0);
      check_eq("t6_rst_adr", 64'(adr), 64'd0);
      check_eq("t6_rst_word", 64'(cmd_word), 64'd0);
      check_eq("t6_rst_busy", 64'(busy), 64'd0);
      check_eq("t6_rst_init", 64'(init_done), 64'd0);
      repeat (2) @(negedge clk);
      push_wr(8'h14, 32'h0);
      push_wr(8'h10, 32'h3010);
      rst = 1'b0;
      for (int n = 0; n < 20 && !init_done; n++) @(negedge clk);
      check_eq("t6_reinit", 64'(init_done), 64'd1);
      auto_int = 1'b1;
      push_xfer(3, 16'h3334, 1'b1);
      do_req(3, 16'h3334);
      wait_idle();

      check_eq("left_writes", 64'(exp_q.size()), 64'd0);
      check_eq("left_grants", 64'(gnt_exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
